// File: rtl/apb_core_master_pkg.sv
// Shared definitions for the per-core APB3 master bridge.
//   apbm_state_e       : bridge FSM state encodings
//   ERR_RDATA_DEFAULT  : default read data returned when the watchdog fires
//   clog2()            : ceiling log2, used to size the watchdog counter
package apb_core_master_pkg;

    typedef enum logic [1:0] {
        APBM_IDLE   = 2'd0,
        APBM_SETUP  = 2'd1,
        APBM_ACCESS = 2'd2
    } apbm_state_e;

    localparam logic [15:0] ERR_RDATA_DEFAULT = 16'hDEAD;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_core_master_if.sv
// APB3 bus slice between one core bridge and the interconnect.
//   M_PADDR/M_PWRITE/M_PSELx/M_PENABLE/M_PWDATA : driven by the master
//   M_PRDATA/M_PREADY                           : driven by the slave side
// Modports: master (bridge view), slave (interconnect / bus model view).
interface apb_core_master_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
);
    logic [BUS_WIDTH-1:0]  M_PADDR;
    logic                  M_PWRITE;
    logic                  M_PSELx;
    logic                  M_PENABLE;
    logic [DATA_WIDTH-1:0] M_PWDATA;
    logic [DATA_WIDTH-1:0] M_PRDATA;
    logic                  M_PREADY;

    modport master (
        output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport slave (
        input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface

// File: rtl/apb_core_master.sv
// Per-core APB3 master bridge. Turns a core load/store request into an APB
// SETUP/ACCESS transfer and returns a one-cycle response. A watchdog ends an
// ACCESS phase that sees no PREADY for TIMEOUT_CYCLES cycles with an error.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req/req_we/req_addr/req_wdata/req_ready : core request handshake
//   rsp_valid/rsp_rdata/rsp_err             : core response
//   apb                  : APB master side (apb_core_master_if.master)
//
// state       | meaning
// APBM_IDLE   | no transfer, req_ready=1
// APBM_SETUP  | PSEL=1, PENABLE=0, one cycle
// APBM_ACCESS | PSEL=1, PENABLE=1, wait for PREADY or watchdog
module apb_core_master
    import apb_core_master_pkg::*;
#(
    parameter int                    BUS_WIDTH      = 16,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    apb_core_master_if.master     apb
);

    // Width covers 0..TIMEOUT_CYCLES; at least one bit when the watchdog is off.
    localparam int CNT_W_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    apbm_state_e           state;
    apbm_state_e           state_next;
    logic                  accept;
    logic                  done_ok;
    logic                  done_timeout;
    logic [CNT_W-1:0]      wait_cnt;
    logic [BUS_WIDTH-1:0]  paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= APBM_IDLE;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= done_ok | done_timeout;
            rsp_err   <= done_timeout;

            if (accept) begin
                paddr  <= req_addr;
                pwrite <= req_we;
                pwdata <= req_wdata;
            end

            if (done_ok) begin
                rsp_rdata <= pwrite ? '0 : apb.M_PRDATA;
            end else if (done_timeout) begin
                rsp_rdata <= ERR_RDATA;
            end

            // Saturating counter: cleared on entry to SETUP, never wraps.
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == APBM_ACCESS && !apb.M_PREADY && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        done_ok      = 1'b0;
        done_timeout = 1'b0;
        case (state)
            APBM_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = APBM_SETUP;
                end
            end
            APBM_SETUP: begin
                state_next = APBM_ACCESS;
            end
            APBM_ACCESS: begin
                // PREADY takes priority over a watchdog expiry in the same cycle.
                if (apb.M_PREADY) begin
                    done_ok    = 1'b1;
                    state_next = APBM_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
                    done_timeout = 1'b1;
                    state_next   = APBM_IDLE;
                end
            end
            default: begin
                state_next = APBM_IDLE;
            end
        endcase
    end

    assign req_ready     = (state == APBM_IDLE);
    assign apb.M_PSELx   = (state != APBM_IDLE);
    assign apb.M_PENABLE = (state == APBM_ACCESS);
    assign apb.M_PADDR   = paddr;
    assign apb.M_PWRITE  = pwrite;
    assign apb.M_PWDATA  = pwdata;

endmodule
